// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: default word width, ALU opcodes
// and the sequencer FSM state type.
package alu_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT = 32;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPTURE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_timeout_ctr.sv
// Counts consecutive cycles spent waiting on the ALU; expired flags the
// TIMEOUT-th waiting cycle.
module alu_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of earlier enabled cycles, so the current
    // cycle is the TIMEOUT-th one when cnt_q reaches TIMEOUT-1.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: latches operands, handshakes with an external
// ALU (with timeout), captures the result and flags into the Z register.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [WORD_SIZE-1:0] bus_in,
    input  logic                 a_load,
    input  logic                 start,
    input  logic [4:0]           op_sel,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] z_lo,
    output logic [WORD_SIZE-1:0] z_hi,
    output logic                 carry,
    output logic                 zero,
    output logic                 err,
    output logic                 alu_req,
    output logic [4:0]           alu_sel,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic                 alu_ack,
    input  logic [WORD_SIZE-1:0] alu_res_lo,
    input  logic [WORD_SIZE-1:0] alu_res_hi,
    input  logic                 alu_carry
);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] y_q, y_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [4:0]           sel_q, sel_d;
    logic [WORD_SIZE-1:0] z_lo_q, z_lo_d;
    logic [WORD_SIZE-1:0] z_hi_q, z_hi_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;
    logic                 dz_q, dz_d;
    logic                 expired;

    alu_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clock  (clock),
        .rst    (clear),
        .clear  (state_q != ST_REQ),
        .enable (state_q == ST_REQ),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        b_d     = b_q;
        sel_d   = sel_q;
        z_lo_d  = z_lo_q;
        z_hi_d  = z_hi_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (a_load) begin
                    y_d = bus_in;
                end
                if (start) begin
                    b_d   = bus_in;
                    sel_d = op_sel;
                    // Divide by zero never reaches the ALU; CAPTURE still
                    // runs so zero/err settle through the normal path.
                    if (op_sel == OP_DIV && bus_in == '0) begin
                        z_lo_d  = '0;
                        z_hi_d  = '0;
                        carry_d = 1'b0;
                        dz_d    = 1'b1;
                        state_d = ST_CAPTURE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (alu_ack) begin
                    z_lo_d  = alu_res_lo;
                    z_hi_d  = alu_res_hi;
                    carry_d = alu_carry;
                    state_d = ST_CAPTURE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                zero_d  = (z_lo_q == '0) && (z_hi_q == '0);
                err_d   = dz_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            z_lo_q  <= '0;
            z_hi_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            z_lo_q  <= z_lo_d;
            z_hi_q  <= z_hi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            dz_q    <= dz_d;
        end
    end

    assign busy    = (state_q == ST_REQ) || (state_q == ST_CAPTURE);
    assign done    = (state_q == ST_DONE);
    assign alu_req = (state_q == ST_REQ);
    assign alu_sel = sel_q;
    assign alu_a   = y_q;
    assign alu_b   = b_q;
    assign z_lo    = z_lo_q;
    assign z_hi    = z_hi_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized
// operations, with the bench acting as the ALU and tracking expected state.
module tb_alu_sequencer;

    localparam int TO = 64;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic        a_load;
    logic        start;
    logic [4:0]  op_sel;
    logic        busy;
    logic        done;
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic        carry;
    logic        zero;
    logic        err;
    logic        alu_req;
    logic [4:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ack;
    logic [31:0] alu_res_lo;
    logic [31:0] alu_res_hi;
    logic        alu_carry;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_y, m_b, m_zlo, m_zhi;
    logic [4:0]  m_sel;
    logic        m_carry, m_zero, m_err;

    alu_sequencer #(
        .WORD_SIZE(32),
        .TIMEOUT  (TO)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .bus_in    (bus_in),
        .a_load    (a_load),
        .start     (start),
        .op_sel    (op_sel),
        .busy      (busy),
        .done      (done),
        .z_lo      (z_lo),
        .z_hi      (z_hi),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .alu_req   (alu_req),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ack   (alu_ack),
        .alu_res_lo(alu_res_lo),
        .alu_res_hi(alu_res_hi),
        .alu_carry (alu_carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU: {carry, hi, lo}
    function automatic logic [64:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        case (op)
            5'd0: begin s = {1'b0, a} + {1'b0, b}; return {s[32], 32'h0, s[31:0]}; end
            5'd1: begin s = {1'b0, a} - {1'b0, b}; return {s[32], 32'h0, s[31:0]}; end
            5'd2: return {1'b0, a % b, a / b};
            5'd3: return {1'b0, 32'h0, a & b};
            5'd4: return {1'b0, 32'h0, a | b};
            default: return {1'b0, 32'h0, a ^ b};
        endcase
    endfunction

    task automatic model_reset();
        m_y = '0; m_b = '0; m_sel = '0; m_zlo = '0; m_zhi = '0;
        m_carry = 1'b0; m_zero = 1'b1; m_err = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " alu_req"}, alu_req, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " carry"}, carry, 0);
        chk({tag, " zero"}, zero, 1);
        chk({tag, " z_lo"}, z_lo, 0);
        chk({tag, " z_hi"}, z_hi, 0);
        chk({tag, " alu_a"}, alu_a, 0);
        chk({tag, " alu_b"}, alu_b, 0);
        chk({tag, " alu_sel"}, alu_sel, 0);
    endtask

    // Called with the DUT in its done cycle; finishes with it back in idle.
    task automatic check_done(input string tag);
        chk({tag, " done_pulse"}, done, 1);
        chk({tag, " done_busy"}, busy, 0);
        chk({tag, " done_req"}, alu_req, 0);
        chk({tag, " z_lo"}, z_lo, m_zlo);
        chk({tag, " z_hi"}, z_hi, m_zhi);
        chk({tag, " carry"}, carry, m_carry);
        chk({tag, " zero"}, zero, m_zero);
        chk({tag, " err"}, err, m_err);
        chk({tag, " hold_a"}, alu_a, m_y);
        chk({tag, " hold_b"}, alu_b, m_b);
        chk({tag, " hold_sel"}, alu_sel, m_sel);
        step();
        chk({tag, " done_once"}, done, 0);
        chk({tag, " idle_busy"}, busy, 0);
    endtask

    // ack_at: REQ cycle index on which the ALU acknowledges; -1 never acks.
    task automatic do_op(input string tag, input bit load, input bit same,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input int ack_at, input bit poke);
        logic [64:0] r;
        int          cyc;
        bit          acked;
        r = '0;
        if (load && !same) begin
            bus_in = a; a_load = 1'b1;
            step();
            a_load = 1'b0;
            m_y = a;
            chk({tag, " y_load"}, alu_a, m_y);
        end
        bus_in = b; op_sel = op; start = 1'b1; a_load = load && same;
        step();
        start = 1'b0; a_load = 1'b0;
        if (load && same) m_y = b;
        m_b = b; m_sel = op;
        chk({tag, " start_busy"}, busy, 1);
        chk({tag, " start_a"}, alu_a, m_y);
        chk({tag, " start_b"}, alu_b, m_b);
        chk({tag, " start_sel"}, alu_sel, m_sel);
        if (op == 5'd2 && b == 32'h0) begin
            chk({tag, " dz_noreq"}, alu_req, 0);
            chk({tag, " dz_nodone"}, done, 0);
            step();
            m_zlo = '0; m_zhi = '0; m_carry = 1'b0; m_zero = 1'b1; m_err = 1'b1;
            check_done(tag);
            return;
        end
        acked = 1'b0;
        cyc   = 0;
        while (!acked && cyc < TO) begin
            chk({tag, " req_high"}, alu_req, 1);
            chk({tag, " req_a"}, alu_a, m_y);
            chk({tag, " req_b"}, alu_b, m_b);
            chk({tag, " req_sel"}, alu_sel, m_sel);
            chk({tag, " req_nodone"}, done, 0);
            if (poke) begin
                start = 1'b1; a_load = 1'b1; bus_in = ~b; op_sel = op ^ 5'h1;
            end
            if (cyc == ack_at) begin
                r = alu_model(op, m_y, m_b);
                alu_ack = 1'b1;
                alu_res_lo = r[31:0]; alu_res_hi = r[63:32]; alu_carry = r[64];
                acked = 1'b1;
            end
            step();
            alu_ack = 1'b0; start = 1'b0; a_load = 1'b0;
            cyc++;
        end
        if (acked) begin
            m_zlo = r[31:0]; m_zhi = r[63:32]; m_carry = r[64];
            chk({tag, " cap_req"}, alu_req, 0);
            chk({tag, " cap_busy"}, busy, 1);
            chk({tag, " cap_nodone"}, done, 0);
            chk({tag, " cap_zlo"}, z_lo, m_zlo);
            step();
            m_zero = (m_zlo == 32'h0) && (m_zhi == 32'h0);
            m_err  = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        check_done(tag);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] rb;
        int          rack;
        clear = 1'b1; bus_in = '0; a_load = 0; start = 0; op_sel = '0;
        alu_ack = 0; alu_res_lo = '0; alu_res_hi = '0; alu_carry = 0;
        model_reset();
        step(); step();
        check_reset_values("reset");
        clear = 1'b0;
        step();

        // ack without a request is ignored
        alu_ack = 1'b1; alu_res_lo = 32'd123; alu_res_hi = 32'd7; alu_carry = 1'b1;
        step();
        alu_ack = 1'b0;
        check_reset_values("stray_ack");

        do_op("basic_add", 1, 0, 32'd5, 32'd3, 5'd0, 0, 0);
        chk("basic_add zlo8", m_zlo, 32'd8);
        do_op("div_zero", 0, 0, 32'd0, 32'd0, 5'd2, 0, 0);
        do_op("timeout", 1, 0, 32'd9, 32'd4, 5'd1, -1, 0);
        do_op("busy_ignore", 1, 0, 32'h1234, 32'h00ff, 5'd3, 5, 1);
        do_op("wrap_zero", 1, 0, 32'hFFFFFFFF, 32'd1, 5'd0, 0, 0);
        do_op("same_cycle", 1, 1, 32'h0, 32'hA5A5_0F0F, 5'd5, 2, 0);
        do_op("div_ok", 1, 0, 32'd1000, 32'd7, 5'd2, 1, 0);

        for (int i = 0; i < 30; i++) begin
            rop  = 5'($urandom_range(0, 5));
            rb   = $urandom;
            if (rop == 5'd2 && $urandom_range(0, 2) == 0) rb = 32'h0;
            rack = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 6));
            do_op("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom, rb, rop, rack, $urandom_range(0, 3) == 0);
        end

        // clear while the request is outstanding, then a late ack
        bus_in = 32'd7; op_sel = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("abort req_high", alu_req, 1);
        step();
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        check_reset_values("abort_async");
        alu_ack = 1'b1; alu_res_lo = 32'hDEAD; alu_res_hi = 32'hBEEF; alu_carry = 1'b1;
        #1;
        clear = 1'b0;
        step();
        alu_ack = 1'b0;
        check_reset_values("abort_late_ack");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort no_done", done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 32, operand/result word width.
REQ-002 Parameter TIMEOUT, default 64, max cycles waiting for alu_ack.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 clear  input  1  reset; asynchronous, active-high.
REQ-005 bus_in  input  WORD_SIZE  shared datapath bus; operand source.
REQ-006 a_load  input  1  latch bus_in into operand register Y.
REQ-007 start  input  1  begin operation; bus_in is operand B this cycle.
REQ-008 op_sel  input  5  operation code, sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 z_lo  output  WORD_SIZE  low result word (Z register low).
REQ-012 z_hi  output  WORD_SIZE  high result word (Z register high).
REQ-013 carry  output  1  captured carry-out flag.
REQ-014 zero  output  1  high when z_lo and z_hi are both zero.
REQ-015 err  output  1  last operation failed (div-by-zero or timeout).
REQ-016 alu_req  output  1  request to ALU; held until acknowledged.
REQ-017 alu_sel  output  5  operation code presented to ALU.
REQ-018 alu_a  output  WORD_SIZE  operand A to ALU (value of Y).
REQ-019 alu_b  output  WORD_SIZE  operand B to ALU (latched at start).
REQ-020 alu_ack  input  1  ALU result valid this cycle.
REQ-021 alu_res_lo / alu_res_hi  input  WORD_SIZE each  ALU result words.
REQ-022 alu_carry  input  1  ALU carry-out.

Function
REQ-023 FSM states SHALL be IDLE, REQ, CAPTURE, DONE.
REQ-024 IDLE: a_load high SHALL latch bus_in into Y; start high SHALL latch bus_in into B, op_sel into alu_sel, and go to REQ.
REQ-025 a_load and start in the same IDLE cycle SHALL load bus_in into both Y and B.
REQ-026 a_load and start while busy SHALL be ignored; Y, B, alu_sel unchanged.
REQ-027 REQ: alu_req SHALL be high, alu_a/alu_b/alu_sel stable; alu_ack sampled high SHALL capture alu_res_lo, alu_res_hi, alu_carry into z_lo, z_hi, carry and go to CAPTURE.
REQ-028 alu_ack while alu_req is low SHALL be ignored.
REQ-029 CAPTURE SHALL update zero from captured Z, clear err, go to DONE; DONE SHALL assert done for exactly one cycle, deassert busy, return to IDLE.
REQ-030 Latency: start at edge k, ack sampled at edge m; done SHALL be high in the cycle after edge m+1 (minimum 4 cycles start-to-done with ack at k+1).
REQ-031 op_sel = 2 (DIV) with B = 0 SHALL skip REQ (no alu_req), set z_lo=z_hi=0, carry=0, zero=1, err=1, and go to DONE via CAPTURE.
REQ-032 Timeout counter SHALL reset on REQ entry and increment each REQ cycle; reaching TIMEOUT without ack SHALL drop alu_req, leave Z unchanged, set err=1, go to DONE.
REQ-033 Z, carry, zero, err SHALL hold their values between operations.

Reset
REQ-034 clear SHALL immediately force IDLE; alu_req, busy, done, err, carry=0; zero=1; z_lo, z_hi, Y, B, alu_sel, counter=0.
REQ-035 clear asserted mid-operation SHALL abort it with no done pulse; a late alu_ack after clear SHALL be ignored.

Structure
REQ-036 Shared package alu_pkg SHALL hold WORD_SIZE default, opcodes (ADD=0, SUB=1, DIV=2, AND=3, OR=4, XOR=5), and the FSM state type.
REQ-037 One sub-module, alu_timeout_ctr (clear/enable/expired), SHALL implement the timeout counter.

Verification
REQ-038 a_load bus=5, start bus=3 op=0, ack next cycle with lo=8 -> z_lo=8, zero=0, err=0, done one cycle, 4 cycles start-to-done.
REQ-039 op=2, B=0 -> alu_req never high, z_lo=z_hi=0, zero=1, err=1, done pulse.
REQ-040 op=1, ack withheld -> alu_req drops after 64 REQ cycles, err=1, Z unchanged, done pulse.
REQ-041 start during busy with different bus/op -> ignored; alu_b, alu_sel unchanged until done.
REQ-042 clear asserted while alu_req high, then ack -> all outputs at reset values, no done, state IDLE.
REQ-043 ack with lo=0, hi=0, carry=1 (e.g. ADD FFFFFFFF+1) -> zero=1, carry=1.
